// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter (package arb_pkg).
package arb_pkg;

  localparam int N_REQ  = 8;  // number of requesters
  localparam int IDX_W  = 3;  // log2(N_REQ)
  localparam int HOLD_W = 8;  // width of the consecutive-grant counter

  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;  // hold counter saturates here

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot vector with only bit idx set.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requester bank (master) and the arbiter (slave).
interface rr_arbiter8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);

endinterface

// File: rtl/rr_arbiter8_prio_enc.sv
// rr_prio_enc8: rotating priority encoder. Finds the first set request at or
// after ptr (mod 8), optionally ignoring one requester (mask_idx).
module rr_prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [IDX_W-1:0] mask_idx,
  input  logic             mask_en,
  output logic             any,
  output logic [IDX_W-1:0] win_idx
);

  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] rotated;
  logic [IDX_W-1:0] offset;

  // Rotate so ptr sits at bit 0, pick lowest set bit, then rotate the index back.
  always_comb begin
    masked = req;
    if (mask_en) masked[mask_idx] = 1'b0;
    rotated = N_REQ'({masked, masked} >> ptr);
    offset  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IDX_W'(i);
    end
    any     = |rotated;
    win_idx = offset + ptr;  // 3-bit add wraps mod 8
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: registered round-robin arbiter for 8 requesters with
// zero-bubble handoff. Optional forced preemption of a long-holding owner is
// enabled by defining ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 2..255");
  end

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [N_REQ-1:0]  gnt_q;
  logic [IDX_W-1:0]  gnt_idx_q;
  logic              gnt_valid_q;

  logic              owner_req;
  logic              mask_en;
  logic              any;
  logic [IDX_W-1:0]  win_idx;
  logic              switch_now;

  assign owner_req = bus.req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  // Exclude a still-requesting owner once it has used up its hold budget.
  assign mask_en = (state == GRANT) && owner_req && (hold_cnt == HOLD_LAST);
`else
  assign mask_en = 1'b0;
`endif

  rr_prio_enc8 u_enc (
    .req      (bus.req),
    .ptr      (ptr),
    .mask_idx (gnt_idx_q),
    .mask_en  (mask_en),
    .any      (any),
    .win_idx  (win_idx)
  );

  // Decide whether this edge loads a new winner (fresh grant or handoff).
  always_comb begin
    // NOTE: default first so every path assigns switch_now and no latch is inferred.
    switch_now = 1'b0;
    if (state == IDLE)   switch_now = any;
    else if (!owner_req) switch_now = any;
    else if (mask_en)    switch_now = any;
  end

  // State, pointer, hold counter and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else if (switch_now) begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      state       <= GRANT;
      gnt_q       <= idx_to_onehot(win_idx);
      gnt_idx_q   <= win_idx;
      gnt_valid_q <= 1'b1;
      ptr         <= win_idx + IDX_W'(1);
      hold_cnt    <= '0;
    end else if (state == GRANT) begin
      if (owner_req) begin
`ifdef ARB_TIMEOUT_EN
        // Sole requester at the limit keeps the grant with a fresh budget.
        if (hold_cnt == HOLD_LAST)     hold_cnt <= '0;
        else if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
`else
        if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
`endif
      end else begin
        state       <= IDLE;
        gnt_q       <= '0;
        gnt_idx_q   <= '0;
        gnt_valid_q <= 1'b0;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run   = 1'b0;

  // Model: owner (-1 = idle), round-robin pointer, consecutive hold count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_winner(input logic [7:0] r, input int start, input int excl);
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (start + k) % 8;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_owner = w;
    m_ptr   = (w + 1) % 8;
    m_hold  = 0;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  // One clock edge of the arbitration rules applied to request vector r.
  task automatic model_step(input logic [7:0] r);
    int w;
    if (m_owner >= 0 && r[m_owner]) begin
      if (TIMEOUT && m_hold == MAX_HOLD - 1) begin
        w = find_winner(r, m_ptr, m_owner);
        if (w >= 0) model_grant(w);
        else        m_hold = 0;
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end else begin
      w = find_winner(r, m_ptr, -1);
      if (w >= 0) model_grant(w);
      else        m_owner = -1;
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model and invariants.
  always @(negedge clk) begin
    if (run) begin
      check("gnt_vs_model", bus.gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("idx_vs_model", bus.gnt_idx, (m_owner >= 0) ? m_owner : 0);
      check("valid_vs_model", bus.gnt_valid, (m_owner >= 0) ? 1 : 0);
      check("onehot0", $onehot0(bus.gnt), 1);
      check("gnt_at_idx", bus.gnt[bus.gnt_idx], bus.gnt_valid);
    end
  end

  // Apply r for one edge; returns at the following falling edge.
  task automatic cyc(input logic [7:0] r);
    bus.req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse inside the low phase; outputs must clear at once.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_valid", bus.gnt_valid, 0);
    check("rst_idx", bus.gnt_idx, 0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  logic [7:0] r;

  initial begin
    rst     = 1'b1;
    bus.req = '0;
    #2;
    check("por_gnt", bus.gnt, 0);
    check("por_idx", bus.gnt_idx, 0);
    check("por_valid", bus.gnt_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;

    // Idle return: three cycles of grant 2, then back to idle.
    for (int i = 0; i < 3; i++) begin
      cyc(8'h04);
      check("idle_ret_gnt", bus.gnt, 8'h04);
    end
    cyc(8'h00);
    check("idle_ret_clear", bus.gnt, 8'h00);
    check("idle_ret_valid", bus.gnt_valid, 0);

    // Reset in the middle of a grant, then a fresh grant.
    cyc(8'h10);
    check("midrst_pre", bus.gnt, 8'h10);
    pulse_reset();
    cyc(8'h01);
    check("midrst_post", bus.gnt, 8'h01);

    // All requesting; each owner drops for one cycle after its grant.
    pulse_reset();
    cyc(8'hFF);
    check("rr_first", bus.gnt_idx, 0);
    for (int i = 1; i <= 8; i++) begin
      r = 8'hFF;
      r[(i - 1) % 8] = 1'b0;
      cyc(r);
      check("rr_order", bus.gnt_idx, i % 8);
      check("rr_no_bubble", bus.gnt_valid, 1);
    end

    // Wrap: grant 5 moves ptr to 6, then 7 beats 0, then 0 follows.
    bus.req = '0;
    pulse_reset();
    cyc(8'h20);
    check("wrap_g5", bus.gnt_idx, 5);
    cyc(8'h00);
    cyc(8'h81);
    check("wrap_g7", bus.gnt_idx, 7);
    cyc(8'h01);
    check("wrap_g0", bus.gnt_idx, 0);

    // Hold: requester 3 steady, requester 1 joins at cycle 5.
    bus.req = '0;
    pulse_reset();
    for (int i = 0; i < 40; i++) begin
      cyc((i >= 5) ? 8'h0A : 8'h08);
      if (!TIMEOUT)   check("hold_keep3", bus.gnt_idx, 3);
      else if (i < 16) check("hold_pre_to", bus.gnt_idx, 3);
      else if (i == 16) check("hold_to_switch", bus.gnt_idx, 1);
    end

    // Sole requester never loses its grant.
    bus.req = '0;
    pulse_reset();
    for (int i = 0; i < 50; i++) begin
      cyc(8'h20);
      check("sole_gnt", bus.gnt, 8'h20);
    end

    // Randomized traffic with sticky requests and occasional resets.
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 99) == 0) r = '0;
      cyc(r);
      if ($urandom_range(0, 399) == 0) pulse_reset();
    end

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource among 8 requesters.
- Outputs a registered one-hot grant plus its 3-bit encoded index.
- The index drives the shared datapath select lines.
- Sits between the requester bank and the shared encoder/mux datapath; replaces fixed-priority OR-encoding with fair, lockable grants.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 for this revision.
- IDX_W, 3, width of the encoded grant index (log2 N_REQ).
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; req[i]=1 means requester i wants the resource.
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- gnt_idx  output  3  encoded index of the current owner; 0 when idle.
- gnt_valid  output  1  1 while any grant is active (equals OR of gnt).

Behaviour:
- Reset (async, rst=1): gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, ptr=3'd0, hold_cnt=0, state=IDLE. Outputs go to reset values immediately, independent of clk. This applies mid-grant as well; the grant is dropped immediately.
- ptr: 3-bit round-robin pointer. Search order is ptr, ptr+1, ..., ptr+7, mod 8. First set req bit in that order wins.
- Latency: req sampled at edge t; resulting gnt, gnt_idx and gnt_valid visible after edge t (registered, 1 cycle). No combinational path from req to any output.
- State IDLE:
  - req==0: stay IDLE.
  - Otherwise: grant winner w; gnt=1<<w, gnt_idx=w, gnt_valid=1, ptr=w+1 (wraps 7->0), hold_cnt=0; go GRANT.
- State GRANT, owner o:
  - req[o]==1: keep the grant; hold_cnt increments and saturates at 255.
  - req[o]==0 and other req bits set: re-arbitrate in the same edge from ptr and switch directly to the new winner (zero-bubble handoff). ptr and hold_cnt are updated as in IDLE.
  - req[o]==0 and req==0: clear all outputs; go IDLE.
- Fairness: after owner o is granted, o has the lowest priority on the next arbitration. Any continuously requesting requester is granted within 7 handoffs.
- Simultaneous requests in IDLE: lowest index at or after ptr wins. Example: ptr=0, req=8'b1001_0100 -> grant 2.
- Wrap-around: ptr=7 with req[7] and req[0] both set -> 7 wins, ptr becomes 0.
- Invariants: gnt is always one-hot or zero; gnt[gnt_idx]==gnt_valid.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt==MAX_HOLD-1 and any req bit other than req[o] is set, the next edge forcibly re-arbitrates excluding o.
  - If o is the only requester, o keeps the grant and hold_cnt resets to 0.
  - Forced handoff follows the same ptr rules as a voluntary release.
- Not defined: no forced preemption; hold_cnt is unused and may be optimised away; the owner holds the grant until it drops req.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=8 and IDX_W=3.
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - HOLD_W=8 (hold_cnt width).
- One sub-module, rr_prio_enc8:
  - Combinational.
  - Inputs: req[7:0], ptr[2:0], mask_idx[2:0], mask_en.
  - Outputs: any (1b), win_idx (3b).
  - Method: rotate req by ptr, apply 8-to-3 priority encode, add ptr back mod 8.
  - Mask input supports timeout exclusion.
- The top module holds the state register, ptr, hold_cnt and output registers.

Test Plan:
- Reset mid-grant: grant req=8'h10, assert rst between edges -> gnt=0, gnt_valid=0, gnt_idx=0 immediately. After release, req=8'h01 -> gnt=8'h01 one cycle later.
- Simultaneous: ptr=0, req=8'hFF held, each owner drops its req for one cycle after being granted -> grant order 0,1,2,...,7,0; handoffs have no idle cycle; gnt always one-hot.
- Wrap: force ptr=6 via sequence (grant 5, release), then req=8'h81 -> gnt_idx=7; release -> gnt_idx=0 on the next edge.
- Hold: req=8'h08 steady for 40 cycles, req=8'h02 raised at cycle 5:
  - Without ARB_TIMEOUT_EN: gnt_idx stays 3 for all 40 cycles.
  - With ARB_TIMEOUT_EN and MAX_HOLD=16: gnt_idx switches to 1 at grant cycle 16.
- Sole requester timeout (ARB_TIMEOUT_EN): req=8'h20 only for 50 cycles -> gnt stays 8'h20, gnt_valid never drops.
- Idle return: single req=8'h04 for 3 cycles, then 8'h00 -> gnt=8'h04 for 3 cycles, then gnt=0, gnt_valid=0, state IDLE.
